// File: rtl/udma_rx_ch_merger_if.sv
// ---------------------------------------------------------------------------
// udma_rx_ch_merger_if
// Bundles the two streams around the RX channel merger: the N_CH
// peripheral-side input streams and the single core-side output stream.
//   in_valid_i / in_ready_o      per-channel beat handshake (ready is one-hot)
//   in_data_i / in_datasize_i    per-channel packed beat payload
//   in_dest_i / in_sot_i / in_eot_i
//   out_valid_o / out_ready_i    core-side head-of-FIFO handshake
//   out_data_o .. out_chid_o     head entry payload plus source channel tag
// Modports: slave = merger side, master = peripherals/core side.
// ---------------------------------------------------------------------------
interface udma_rx_ch_merger_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32,
    parameter int DEST_W = 8
);
    localparam int CHID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]        in_valid_i;
    logic [N_CH-1:0]        in_ready_o;
    logic [N_CH*DATA_W-1:0] in_data_i;
    logic [N_CH*2-1:0]      in_datasize_i;
    logic [N_CH*DEST_W-1:0] in_dest_i;
    logic [N_CH-1:0]        in_sot_i;
    logic [N_CH-1:0]        in_eot_i;

    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [DATA_W-1:0]      out_data_o;
    logic [1:0]             out_datasize_o;
    logic [DEST_W-1:0]      out_dest_o;
    logic                   out_sot_o;
    logic                   out_eot_o;
    logic [CHID_W-1:0]      out_chid_o;

    modport slave (
        input  in_valid_i, in_data_i, in_datasize_i, in_dest_i, in_sot_i, in_eot_i,
        output in_ready_o,
        output out_valid_o, out_data_o, out_datasize_o, out_dest_o,
               out_sot_o, out_eot_o, out_chid_o,
        input  out_ready_i
    );

    modport master (
        output in_valid_i, in_data_i, in_datasize_i, in_dest_i, in_sot_i, in_eot_i,
        input  in_ready_o,
        input  out_valid_o, out_data_o, out_datasize_o, out_dest_o,
               out_sot_o, out_eot_o, out_chid_o,
        output out_ready_i
    );
endinterface

// File: rtl/udma_rx_ch_merger.sv
// ---------------------------------------------------------------------------
// udma_rx_ch_merger
// Merges N_CH peripheral RX streams into one core-side RX stream feeding a
// single uDMA RX channel. Round-robin arbitration, optional burst lock from
// an accepted sot beat to the accepted eot beat of the same channel, and a
// DEPTH-entry output FIFO whose head carries the source channel id.
//   clk_i   clock
//   rstn_i  asynchronous active-low reset
//   clr_i   synchronous flush of FIFO, lock and round-robin pointer
//   bus     merger-side (slave) view of the input and output streams
//   busy_o  FIFO non-empty or a burst lock is held
// ---------------------------------------------------------------------------
module udma_rx_ch_merger #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 32,
    parameter int DEST_W     = 8,
    parameter int DEPTH      = 4,
    parameter int LOCK_BURST = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clr_i,
    udma_rx_ch_merger_if.slave   bus,
    output logic                 busy_o
);
    localparam int CHID_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CHID_W-1:0] chid;
        logic [DATA_W-1:0] data;
        logic [1:0]        size;
        logic [DEST_W-1:0] dest;
        logic              sot;
        logic              eot;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic [CHID_W-1:0] r_rrPtr;
    logic              r_lock;
    logic [CHID_W-1:0] r_lockCh;

    logic              w_outValid;
    logic              w_pop;
    logic              w_space;
    logic [N_CH-1:0]   w_elig;
    logic              w_grantValid;
    logic [CHID_W-1:0] w_grantCh;
    logic              w_push;
    entry_t            w_pushEntry;
    entry_t            w_head;

    assign w_outValid = (r_count != '0);
    assign w_pop      = w_outValid & bus.out_ready_i & ~clr_i;
    // A full FIFO still has room when its head leaves in the same cycle.
    assign w_space    = (r_count < CNT_W'(DEPTH)) | (w_outValid & bus.out_ready_i);

    // Eligibility and round-robin grant: scan starting at the pointer, the
    // first eligible channel wins. While locked only the lock owner is eligible.
    always_comb begin
        w_elig       = '0;
        w_grantValid = 1'b0;
        w_grantCh    = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_elig[k] = bus.in_valid_i[k] & w_space &
                        (~r_lock | (r_lockCh == CHID_W'(k)));
        end
        for (int i = 0; i < N_CH; i++) begin
            int idx;
            idx = (int'(r_rrPtr) + i) % N_CH;
            if (!w_grantValid && w_elig[idx]) begin
                w_grantValid = 1'b1;
                w_grantCh    = CHID_W'(idx);
            end
        end
    end

    // Ready is suppressed during reset and flush so nothing is handshaken
    // that the state update would then discard.
    assign w_push = w_grantValid & ~clr_i & rstn_i;

    always_comb begin
        bus.in_ready_o = '0;
        if (w_push) begin
            bus.in_ready_o[w_grantCh] = 1'b1;
        end
    end

    // Payload of the granted channel, tagged with its index.
    always_comb begin
        w_pushEntry      = '0;
        w_pushEntry.chid = w_grantCh;
        w_pushEntry.data = bus.in_data_i[int'(w_grantCh)*DATA_W +: DATA_W];
        w_pushEntry.size = bus.in_datasize_i[int'(w_grantCh)*2 +: 2];
        w_pushEntry.dest = bus.in_dest_i[int'(w_grantCh)*DEST_W +: DEST_W];
        w_pushEntry.sot  = bus.in_sot_i[w_grantCh];
        w_pushEntry.eot  = bus.in_eot_i[w_grantCh];
    end

    // FIFO, round-robin pointer and burst lock state. Flush wins over any
    // same-cycle push or pop. A sot seen while already locked is plain data.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            r_rrPtr  <= '0;
            r_lock   <= 1'b0;
            r_lockCh <= '0;
        end else if (clr_i) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            r_rrPtr  <= '0;
            r_lock   <= 1'b0;
            r_lockCh <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= w_pushEntry;
                r_wrPtr        <= r_wrPtr + PTR_W'(1);
                r_rrPtr        <= (w_grantCh == CHID_W'(N_CH - 1)) ? '0
                                                                   : w_grantCh + CHID_W'(1);
                if (LOCK_BURST != 0) begin
                    if (r_lock) begin
                        if (w_pushEntry.eot) begin
                            r_lock <= 1'b0;
                        end
                    end else if (w_pushEntry.sot && !w_pushEntry.eot) begin
                        r_lock   <= 1'b1;
                        r_lockCh <= w_grantCh;
                    end
                end
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Outputs come straight from the registered head entry; no bypass.
    assign w_head             = r_mem[r_rdPtr];
    assign bus.out_valid_o    = w_outValid;
    assign bus.out_data_o     = w_head.data;
    assign bus.out_datasize_o = w_head.size;
    assign bus.out_dest_o     = w_head.dest;
    assign bus.out_sot_o      = w_head.sot;
    assign bus.out_eot_o      = w_head.eot;
    assign bus.out_chid_o     = w_head.chid;
    assign busy_o             = w_outValid | r_lock;
endmodule
